// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift step per clock.
// Define BIN_TO_BCD_SIGNED_EN to treat bin_in as two's complement (sign on neg).
module bin_to_bcd_seq #(
    parameter int DATA_W = 32,
    parameter int DIGITS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_W-1:0]     bin_in,
    output logic                  ready,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd_out,
    output logic                  overflow,
    output logic                  neg
);

    localparam int unsigned CNT_W = $clog2(DATA_W + 1);
    localparam int unsigned BCD_W = DIGITS * 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   shiftReg;
    logic [DATA_W-1:0]   operand;
    logic [BCD_W-1:0]    acc;
    logic [BCD_W-1:0]    accAdj;
    logic [CNT_W-1:0]    cnt;

`ifdef BIN_TO_BCD_SIGNED_EN
    logic negReg;

    // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
    assign operand = bin_in[DATA_W-1] ? -bin_in : bin_in;
    assign neg     = negReg;
`else
    assign operand = bin_in;
    assign neg     = 1'b0;
`endif

    assign bcd_out = acc;

    always_comb begin
        accAdj = acc;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (acc[4*k +: 4] > 4'd4) begin
                accAdj[4*k +: 4] = acc[4*k +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            shiftReg <= '0;
            acc      <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
            negReg   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= SHIFT;
                        shiftReg <= operand;
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        done     <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
                        negReg   <= bin_in[DATA_W-1];
`endif
                    end
                end
                SHIFT: begin
                    // A set MSB after adjustment is the bit lost off the top digit.
                    acc      <= {accAdj[BCD_W-2:0], shiftReg[DATA_W-1]};
                    shiftReg <= {shiftReg[DATA_W-2:0], 1'b0};
                    if (accAdj[BCD_W-1]) begin
                        overflow <= 1'b1;
                    end
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state <= DONE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance (DATA_W=16) checked
// every cycle against an arithmetic model, plus literal expectations.
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;
    logic [1:0]  start;
    logic [15:0] binIn0;
    logic [15:0] binIn1;
    logic [1:0]  rdy;
    logic [1:0]  bsy;
    logic [1:0]  dn;
    logic [1:0]  ovf;
    logic [1:0]  ng;
    logic [19:0] bcd5;
    logic [15:0] bcd4;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.DATA_W(16), .DIGITS(5)) dut5 (
        .clk(clk), .rst(rst), .start(start[0]), .bin_in(binIn0),
        .ready(rdy[0]), .busy(bsy[0]), .done(dn[0]),
        .bcd_out(bcd5), .overflow(ovf[0]), .neg(ng[0])
    );

    bin_to_bcd_seq #(.DATA_W(16), .DIGITS(4)) dut4 (
        .clk(clk), .rst(rst), .start(start[1]), .bin_in(binIn1),
        .ready(rdy[1]), .busy(bsy[1]), .done(dn[1]),
        .bcd_out(bcd4), .overflow(ovf[1]), .neg(ng[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result straight from decimal arithmetic.
    task automatic refResult(input logic [15:0] v, input int nd,
                             output logic [19:0] bcd, output logic o, output logic n);
        int unsigned mag;
        mag = v;
        n   = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
        if (v[15]) begin
            n   = 1'b1;
            mag = 65536 - mag;
        end
`endif
        bcd = '0;
        for (int k = 0; k < nd; k++) begin
            bcd[4*k +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        o = (mag != 0);
    endtask

    // Model state per instance: 0 idle, 1 converting, 2 result valid.
    int          mState[2];
    int          mCnt[2];
    logic [19:0] mBcd[2];
    logic        mOvf[2];
    logic        mNeg[2];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mState[i] = 0; mCnt[i] = 0; mBcd[i] = '0; mOvf[i] = 1'b0; mNeg[i] = 1'b0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mState[i] == 1) begin
                    mCnt[i]++;
                    if (mCnt[i] == 16) mState[i] = 2;
                end else if (start[i]) begin
                    mState[i] = 1;
                    mCnt[i]   = 0;
                    refResult(i == 0 ? binIn0 : binIn1, i == 0 ? 5 : 4, mBcd[i], mOvf[i], mNeg[i]);
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("ready%0d", i), {31'b0, rdy[i]}, {31'b0, mState[i] != 1});
                chk($sformatf("busy%0d", i),  {31'b0, bsy[i]}, {31'b0, mState[i] == 1});
                chk($sformatf("done%0d", i),  {31'b0, dn[i]},  {31'b0, mState[i] == 2});
                if (mState[i] != 1) begin
                    chk($sformatf("bcd%0d", i), i == 0 ? {12'b0, bcd5} : {16'b0, bcd4}, {12'b0, mBcd[i]});
                    chk($sformatf("ovf%0d", i), {31'b0, ovf[i]}, {31'b0, mOvf[i]});
                    chk($sformatf("neg%0d", i), {31'b0, ng[i]},  {31'b0, mNeg[i]});
                end
            end
        end
    end

    // Starts a conversion, optionally hammering start during SHIFT, and checks latency.
    task automatic convert(input int i, input logic [15:0] v, input bit spam);
        int n;
        int busyCnt;
        start[i] = 1'b1;
        if (i == 0) binIn0 = v; else binIn1 = v;
        @(posedge clk);
        #1;
        start[i] = spam;
        if (spam) begin
            if (i == 0) binIn0 = 16'($urandom); else binIn1 = 16'($urandom);
        end
        busyCnt = bsy[i] ? 1 : 0;
        n = 0;
        while (n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (dn[i]) break;
            if (bsy[i]) busyCnt++;
            if (spam) begin
                start[i] = (n < 15);
                if (i == 0) binIn0 = 16'($urandom); else binIn1 = 16'($urandom);
            end
        end
        start[i] = 1'b0;
        chk($sformatf("latency%0d", i), n, 16);
        chk($sformatf("busyCycles%0d", i), busyCnt, 16);
    endtask

    initial begin
        int doneSeen;
        rst = 1'b1;
        start = '0;
        binIn0 = '0;
        binIn1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rstReady", {30'b0, rdy}, 32'h3);
        chk("rstBusyDone", {28'b0, bsy, dn}, 32'h0);
        chk("rstBcd", {12'b0, bcd5}, 32'h0);
        chk("rstOvfNeg", {28'b0, ovf, ng}, 32'h0);
        rst = 1'b0;

        convert(0, 16'hFFFF, 1'b0);
        chk("lit65535", {12'b0, bcd5}, 32'h65535);
        chk("lit65535ovf", {31'b0, ovf[0]}, 32'h0);
        convert(0, 16'h0000, 1'b0);
        chk("litZero", {12'b0, bcd5}, 32'h0);

        convert(1, 16'd12345, 1'b0);
        chk("lit2345", {16'b0, bcd4}, 32'h2345);
        chk("lit2345ovf", {31'b0, ovf[1]}, 32'h1);
        convert(1, 16'd9999, 1'b0);
        chk("lit9999", {16'b0, bcd4}, 32'h9999);
        chk("lit9999ovf", {31'b0, ovf[1]}, 32'h0);

        convert(0, 16'd1234, 1'b1);
        chk("litSpam", {12'b0, bcd5}, 32'h01234);
        convert(0, 16'd907, 1'b0);
        chk("litBackToBack", {12'b0, bcd5}, 32'h00907);

        // Abort mid-conversion with an asynchronous reset.
        start[0] = 1'b1;
        binIn0 = 16'd777;
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abortReady", {31'b0, rdy[0]}, 32'h1);
        chk("abortBusyDone", {30'b0, bsy[0], dn[0]}, 32'h0);
        chk("abortBcd", {12'b0, bcd5}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        doneSeen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (dn[0]) doneSeen++;
        end
        chk("abortNoDone", doneSeen, 0);
        convert(0, 16'd42, 1'b0);
        chk("lit42", {12'b0, bcd5}, 32'h00042);

        convert(0, 16'hFB2E, 1'b0);
`ifdef BIN_TO_BCD_SIGNED_EN
        chk("litNeg1234", {11'b0, ng[0], bcd5}, {11'b0, 1'b1, 20'h01234});
`else
        chk("litU64302", {11'b0, ng[0], bcd5}, {11'b0, 1'b0, 20'h64302});
`endif
        convert(0, 16'h8000, 1'b0);
        chk("lit32768", {11'b0, ng[0], bcd5},
`ifdef BIN_TO_BCD_SIGNED_EN
            {11'b0, 1'b1, 20'h32768});
`else
            {11'b0, 1'b0, 20'h32768});
`endif

        for (int t = 0; t < 16; t++) begin
            int unsigned gap;
            gap = $urandom_range(0, 2);
            repeat (gap) @(posedge clk);
            #1;
            convert(int'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
